rs_decoder: RTL and testbench

- Receive-side counterpart of the RS(15,11) systematic encoder over GF(16).
- Field polynomial x^4+x+1. Generator roots alpha^0..alpha^3, so g(x) = x^4 + 15x^3 + 3x^2 + 1x + 12.
- Accepts 15-symbol codewords: 11 data symbols, highest degree first, then 4 parity symbols.
- Computes the 4 syndromes, corrects any single-symbol error, flags uncorrectable blocks, and emits the 11 data symbols. Sits between the channel/deserializer and the consumer.

---
 rtl/rs_decoder.sv | 193 +++++++++++++++++++
 tb/tb_rs_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decoder.sv
// RS(15,11) over GF(16) (x^4+x+1) receive decoder: Horner syndromes, ping-pong data buffer, 11-symbol emit.
// Define RS_DEC_CORRECT_EN for single-symbol correction; undefined builds a detect-only decoder.
module rs_decoder (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic [3:0] in_data,
  output logic       out_valid,
  output logic       out_start,
  output logic       out_last,
  output logic [3:0] out_data,
  output logic       out_corrected,
  output logic       out_fail
);
  localparam int N     = 15;
  localparam int K     = 11;
  localparam int SYM_W = 4;

  localparam logic [3:0] LAST_SYM  = 4'(N - 1);
  localparam logic [3:0] LAST_DATA = 4'(K - 1);

  typedef logic [SYM_W-1:0] sym_t;
  typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;

  function automatic sym_t mul_a(sym_t x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  // ---------------- input side ----------------
  logic [3:0]  cnt_q, cnt_d;
  sym_t [3:0]  syn_q, syn_d;
  sym_t [3:0]  bsyn_q [2];
  sym_t        mem_q  [2][K];
  logic        wr_bank_q;
  logic        start_hit, accept, hand;
  logic [3:0]  wr_idx;

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    start_hit = in_valid && in_start;
    accept    = in_valid && (in_start || cnt_q != 4'd0);
    hand      = accept && !in_start && cnt_q == LAST_SYM;
    wr_idx    = in_start ? 4'd0 : cnt_q;
    cnt_d     = cnt_q;
    syn_d     = syn_q;
    if (start_hit) begin
      cnt_d = 4'd1;
      for (int j = 0; j < 4; j++) syn_d[j] = in_data;
    end else if (accept) begin
      cnt_d    = hand ? 4'd0 : cnt_q + 4'd1;
      syn_d[0] = syn_q[0] ^ in_data;
      syn_d[1] = mul_a(syn_q[1]) ^ in_data;
      syn_d[2] = mul_a(mul_a(syn_q[2])) ^ in_data;
      syn_d[3] = mul_a(mul_a(mul_a(syn_q[3]))) ^ in_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q     <= 4'd0;
      syn_q     <= '0;
      bsyn_q[0] <= '0;
      bsyn_q[1] <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      syn_q <= syn_d;
      if (hand) begin
        bsyn_q[wr_bank_q] <= syn_d;
        wr_bank_q         <= ~wr_bank_q;
      end
    end
  end

  // NOTE: the data buffer has no reset; the full flags alone decide whether a bank is read.
  always_ff @(posedge sys_clk) begin
    if (accept && wr_idx <= LAST_DATA) mem_q[wr_bank_q][wr_idx] <= in_data;
  end

  // ---------------- output side ----------------
  state_t      state_q;
  logic        rd_bank_q;
  logic [3:0]  k_q;
  logic        single_q, fail_q;
  logic [1:0]  full_q;
  sym_t [3:0]  s;
  logic        no_err, eval_single, eval_fail;
  logic        next_bank, ready_next;
  sym_t        fix_sym;

  assign s      = bsyn_q[rd_bank_q];
  assign no_err = (s == '0);

  // At the end of EMIT the candidate is the other bank; a handoff this very cycle also counts.
  always_comb begin
    next_bank  = (state_q == EMIT) ? ~rd_bank_q : rd_bank_q;
    ready_next = full_q[next_bank] || (hand && wr_bank_q == next_bank);
  end

`ifdef RS_DEC_CORRECT_EN
  sym_t t_q;

  function automatic sym_t mul_ainv(sym_t x);
    return x[0] ? (((x ^ 4'h3) >> 1) | 4'h8) : (x >> 1);
  endfunction

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t acc, sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = mul_a(sh);
    end
    return acc;
  endfunction

  assign eval_single = s[0] != '0 && s[1] != '0 &&
                       gf_mul(s[1], s[1]) == gf_mul(s[0], s[2]) &&
                       gf_mul(s[2], s[2]) == gf_mul(s[1], s[3]);
  assign eval_fail   = !no_err && !eval_single;
  // T tracks S0*alpha^(14-k); a hit against S1 locates the error at symbol k.
  assign fix_sym     = (single_q && t_q == s[1]) ? s[0] : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                t_q <= '0;
    else if (state_q == EVAL)   t_q <= mul_ainv(s[0]);
    else if (state_q == EMIT)   t_q <= mul_ainv(t_q);
  end
`else
  assign eval_single = 1'b0;
  assign eval_fail   = !no_err;
  assign fix_sym     = '0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      full_q <= 2'b00;
    end else begin
      if (state_q == EMIT && k_q == LAST_DATA) full_q[rd_bank_q] <= 1'b0;
      if (hand) full_q[wr_bank_q] <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      rd_bank_q     <= 1'b0;
      k_q           <= 4'd0;
      single_q      <= 1'b0;
      fail_q        <= 1'b0;
      out_valid     <= 1'b0;
      out_start     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_fail      <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_start     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_fail      <= 1'b0;
      case (state_q)
        IDLE: if (ready_next) state_q <= EVAL;
        EVAL: begin
          single_q <= eval_single;
          fail_q   <= eval_fail;
          k_q      <= 4'd0;
          state_q  <= EMIT;
        end
        EMIT: begin
          out_valid <= 1'b1;
          out_start <= (k_q == 4'd0);
          out_last  <= (k_q == LAST_DATA);
          out_data  <= mem_q[rd_bank_q][k_q] ^ fix_sym;
          k_q       <= k_q + 4'd1;
          if (k_q == LAST_DATA) begin
            out_corrected <= single_q;
            out_fail      <= fail_q;
            rd_bank_q     <= ~rd_bank_q;
            state_q       <= ready_next ? EVAL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_decoder.sv
// Self-checking bench for rs_decoder: directed codewords plus randomized codewords with injected errors,
// checked against a GF(16) polynomial model (encode by division, syndromes by evaluation, log-table search).
module tb_rs_decoder;
  typedef logic [14:0][3:0] cw_t;
  typedef logic [10:0][3:0] dat_t;
  typedef struct packed {
    dat_t data;
    logic corr;
    logic fail;
  } blk_t;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_start = 1'b0;
  logic [3:0] in_data  = 4'd0;
  logic       out_valid, out_start, out_last, out_corrected, out_fail;
  logic [3:0] out_data;

  always #5 sys_clk = ~sys_clk;

  rs_decoder dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .in_valid      (in_valid),
    .in_start      (in_start),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_start     (out_start),
    .out_last      (out_last),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .out_fail      (out_fail)
  );

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_sent   = 0;
  int   n_blocks = 0;
  int   alog [15];
  int   glog [16];
  blk_t exp_q  [$];
  time  hand_q [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
    if (a == 4'd0 || b == 4'd0) return 4'd0;
    return 4'(alog[(glog[a] + glog[b]) % 15]);
  endfunction

  // Symbol index i of a codeword carries degree 14-i.
  function automatic cw_t encode(dat_t d);
    logic [3:0] c  [15];
    logic [3:0] gp [5];
    logic [3:0] coef;
    cw_t w;
    gp = '{4'd12, 4'd1, 4'd3, 4'd15, 4'd1};
    for (int i = 0; i < 15; i++) c[i] = 4'd0;
    for (int i = 0; i < 11; i++) c[14-i] = d[i];
    for (int deg = 14; deg >= 4; deg--) begin
      coef = c[deg];
      for (int t = 0; t < 5; t++) c[deg-4+t] ^= gmul(coef, gp[t]);
    end
    for (int i = 0; i < 11; i++) w[i] = d[i];
    for (int i = 11; i < 15; i++) w[i] = c[14-i];
    return w;
  endfunction

  function automatic blk_t model(cw_t w);
    blk_t b;
    logic [3:0] s [4];
    logic no_err;
    for (int j = 0; j < 4; j++) begin
      s[j] = 4'd0;
      for (int i = 0; i < 15; i++) s[j] ^= gmul(w[i], 4'(alog[(j * (14 - i)) % 15]));
    end
    for (int i = 0; i < 11; i++) b.data[i] = w[i];
    no_err = (s[0] == 0 && s[1] == 0 && s[2] == 0 && s[3] == 0);
`ifdef RS_DEC_CORRECT_EN
    begin
      logic single;
      single = s[0] != 0 && s[1] != 0 &&
               gmul(s[1], s[1]) == gmul(s[0], s[2]) &&
               gmul(s[2], s[2]) == gmul(s[1], s[3]);
      b.corr = single;
      b.fail = !no_err && !single;
      if (single)
        for (int d = 4; d < 15; d++)
          if (gmul(s[0], 4'(alog[d])) == s[1]) b.data[14-d] ^= s[0];
    end
`else
    b.corr = 1'b0;
    b.fail = !no_err;
`endif
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(logic v, logic st, logic [3:0] d);
    in_valid = v;
    in_start = st;
    in_data  = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    in_start = 1'b0;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_cw(cw_t w, int gap_max);
    for (int i = 0; i < 15; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) drive(1'b0, 1'b0, 4'($urandom));
      drive(1'b1, i == 0, w[i]);
    end
    exp_q.push_back(model(w));
    hand_q.push_back($time - 1);
    n_sent++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (16) @(negedge sys_clk);
  endtask

  // ---------------- output monitor ----------------
  int   mon_k    = 0;
  blk_t cur;
  logic have_cur = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      mon_k = 0;
    end else if (out_valid) begin
      if (mon_k == 0) begin
        check("start_flag", out_start, 1);
        have_cur = (exp_q.size() != 0);
        check("block_expected", have_cur, 1);
        if (have_cur) begin
          cur = exp_q.pop_front();
          check("latency", 32'($time - hand_q.pop_front()), 25);
        end
      end else begin
        check("start_flag", out_start, 0);
      end
      if (have_cur) check($sformatf("data_k%0d", mon_k), out_data, cur.data[mon_k]);
      check("last_flag", out_last, mon_k == 10);
      if (mon_k == 10) begin
        if (have_cur) begin
          check("corrected", out_corrected, cur.corr);
          check("fail", out_fail, cur.fail);
        end
        mon_k = 0;
        n_blocks++;
      end else begin
        check("status_early", {out_corrected, out_fail}, 0);
        mon_k++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    cw_t  zcw, gcw, w;
    dat_t d;
    int   v, n, ne, p1, p2;

    v = 1;
    for (int i = 0; i < 15; i++) begin
      alog[i] = v;
      glog[v] = i;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 19;
    end
    glog[0] = 0;

    zcw = '0;
    gcw = '0;
    gcw[10] = 4'd1; gcw[11] = 4'd15; gcw[12] = 4'd3; gcw[13] = 4'd1; gcw[14] = 4'd12;

    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_valid", out_valid, 0);
    check("rst_start", out_start, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_corrected", out_corrected, 0);
    check("rst_fail", out_fail, 0);
    @(posedge sys_clk); #1;

    send_cw(zcw, 0); idle(20);
    send_cw(gcw, 0); send_cw(gcw, 0); send_cw(gcw, 0); idle(20);

    w = gcw; w[3] = 4'd5;             send_cw(w, 0); idle(20);
    w = zcw; w[13] = 4'd9;            send_cw(w, 0); idle(20);
    w = zcw; w[2] = 4'd7; w[8] = 4'd1; send_cw(w, 0); idle(20);

    // Abandoned partial block: only the following clean codeword may come out.
    for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 4'(i + 3));
    send_cw(gcw, 0); idle(20);
    drain();

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 11; i++) d[i] = 4'($urandom_range(0, 15));
      w  = encode(d);
      ne = $urandom_range(0, 2);
      p1 = $urandom_range(0, 14);
      p2 = (p1 + 1 + $urandom_range(0, 13)) % 15;
      if (ne >= 1) w[p1] ^= 4'($urandom_range(1, 15));
      if (ne == 2) w[p2] ^= 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 3)) drive(1'b1, 1'b0, 4'($urandom));
      send_cw(w, (k % 2) * 2);
    end
    idle(1);
    drain();

    // Reset in the middle of an emit.
    w = gcw; w[5] = 4'd6;
    send_cw(w, 0); idle(0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("rst_emit_seen", out_valid, 1);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_data", out_data, 0);
    void'(exp_q.size());

    // Counter must be back at 0: start-less symbols are ignored.
    @(posedge sys_clk); #1;
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'($urandom_range(1, 15)));
    idle(40);
    w = zcw; w[0] = 4'd4;
    send_cw(w, 0); idle(5);
    drain();

    check("queue_empty", exp_q.size(), 0);
    check("block_count", n_blocks, n_sent - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
